// File: rtl/i2c_master_reg_writer_if.sv
// Host-side request/status bundle for the write-only I2C register master.
interface i2c_master_reg_writer_if;
    logic       start;
    logic [6:0] slv_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        output start, slv_addr, reg_addr, wdata,
        input  busy, done, ack_err
    );

    modport slave (
        input  start, slv_addr, reg_addr, wdata,
        output busy, done, ack_err
    );
endinterface

// File: rtl/i2c_master_reg_writer.sv
// Write-only I2C master: one start pulse sends START, {slv_addr,W}, reg_addr, wdata, STOP.
// Optional feature macro I2C_NACK_ABORT_EN: a NACKed slot cuts the transfer short to STOP.
module i2c_master_reg_writer #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned I2C_HZ = 100_000
) (
    input  logic                   clk,
    input  logic                   reset,
    i2c_master_reg_writer_if.slave host,
    output logic                   SCL,
    inout  wire                    SDA
);
    localparam int unsigned QTR = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_A,
        S_REG,
        S_ACK_R,
        S_DATA,
        S_ACK_D,
        S_STOP
    } state_t;

    state_t          state, state_n;
    logic [1:0]      q, q_n;
    logic [QW-1:0]   qcnt, qcnt_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic [6:0]      addr_q, addr_n;
    logic [7:0]      reg_q, reg_n;
    logic [7:0]      data_q, data_n;
    logic            busy, busy_n;
    logic            done, done_n;
    logic            ack_err, ack_err_n;
    logic            scl_q, scl_n;
    logic            sda_low, sda_low_n;
    logic            tick;
    logic            is_ack;
    logic            sda_in;

    // Open-drain SDA: only ever pulled low, released otherwise.
    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;
    assign SCL    = scl_q;

    assign host.busy    = busy;
    assign host.done    = done;
    assign host.ack_err = ack_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            q       <= 2'd0;
            qcnt    <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            addr_q  <= 7'd0;
            reg_q   <= 8'd0;
            data_q  <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            scl_q   <= 1'b1;
            sda_low <= 1'b0;
        end else begin
            state   <= state_n;
            q       <= q_n;
            qcnt    <= qcnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            addr_q  <= addr_n;
            reg_q   <= reg_n;
            data_q  <= data_n;
            busy    <= busy_n;
            done    <= done_n;
            ack_err <= ack_err_n;
            scl_q   <= scl_n;
            sda_low <= sda_low_n;
        end
    end

    // Next state, then bus levels derived from the next state so SCL/SDA are registered.
    always_comb begin
        state_n   = state;
        q_n       = q;
        qcnt_n    = qcnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        addr_n    = addr_q;
        reg_n     = reg_q;
        data_n    = data_q;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = ack_err;
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        tick      = 1'b0;
        is_ack    = (state == S_ACK_A) || (state == S_ACK_R) || (state == S_ACK_D);

        if (state == S_IDLE) begin
            qcnt_n = '0;
            q_n    = 2'd0;
            // A start coinciding with the done pulse is dropped.
            if (host.start && !done) begin
                state_n   = S_START;
                busy_n    = 1'b1;
                ack_err_n = 1'b0;
                addr_n    = host.slv_addr;
                reg_n     = host.reg_addr;
                data_n    = host.wdata;
            end
        end else begin
            tick   = (qcnt == QW'(QTR - 1));
            qcnt_n = tick ? '0 : QW'(qcnt + 1'b1);
            if (tick) begin
                q_n = q + 2'd1;
                if (is_ack && (q == 2'd1) && sda_in) begin
                    ack_err_n = 1'b1;
                end
                if (q == 2'd3) begin
                    unique case (state)
                        S_START: begin
                            state_n   = S_ADDR;
                            shreg_n   = {addr_q, 1'b0};
                            bit_cnt_n = 3'd0;
                        end
                        S_ADDR, S_REG, S_DATA: begin
                            shreg_n   = {shreg[6:0], 1'b0};
                            bit_cnt_n = 3'(bit_cnt + 3'd1);
                            if (bit_cnt == 3'd7) begin
                                state_n = (state == S_ADDR) ? S_ACK_A :
                                          (state == S_REG)  ? S_ACK_R : S_ACK_D;
                            end
                        end
                        S_ACK_A, S_ACK_R, S_ACK_D: begin
                            if (state == S_ACK_A) begin
                                state_n = S_REG;
                                shreg_n = reg_q;
                            end else if (state == S_ACK_R) begin
                                state_n = S_DATA;
                                shreg_n = data_q;
                            end else begin
                                state_n = S_STOP;
                            end
`ifdef I2C_NACK_ABORT_EN
                            // ack_err was sampled at the end of q1 of this very slot.
                            if (ack_err) begin
                                state_n = S_STOP;
                            end
`endif
                        end
                        S_STOP: begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        end

        // Quarter-phase bus levels: q0 low, q1/q2 high, q3 low within a bit slot.
        unique case (state_n)
            S_START: begin
                scl_n     = (q_n != 2'd3);
                sda_low_n = q_n[1];
            end
            S_ADDR, S_REG, S_DATA: begin
                scl_n     = (q_n == 2'd1) || (q_n == 2'd2);
                sda_low_n = ~shreg_n[7];
            end
            S_ACK_A, S_ACK_R, S_ACK_D: begin
                scl_n     = (q_n == 2'd1) || (q_n == 2'd2);
                sda_low_n = 1'b0;
            end
            S_STOP: begin
                scl_n     = (q_n != 2'd0);
                sda_low_n = ~q_n[1];
            end
            default: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_master_reg_writer.sv
// Scoreboard bench for i2c_master_reg_writer with a behavioural I2C slave that ACKs 7'h42 only.
module tb_i2c_master_reg_writer;
    localparam int unsigned CLK_HZ = 4_000_000;
    localparam int unsigned I2C_HZ = 100_000;
    localparam int          QTR    = 10;

    logic clk = 1'b0;
    logic reset;
    logic scl;
    wire  sda;
    logic slave_drive = 1'b0;

    i2c_master_reg_writer_if hif();

    pullup (sda);
    assign sda = slave_drive ? 1'b0 : 1'bz;

    i2c_master_reg_writer #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
        .clk   (clk),
        .reset (reset),
        .host  (hif.slave),
        .SCL   (scl),
        .SDA   (sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bytes;
        int          nbytes;
        logic        ack_err;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what a complete transaction must look like on the bus.
    function automatic exp_t model(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        exp_t e;
        bit   nack;
        bit   abort;
        nack = (a != 7'h42);
`ifdef I2C_NACK_ABORT_EN
        abort = nack;
`else
        abort = 1'b0;
`endif
        e.bytes   = {a, 1'b0, r, d};
        e.nbytes  = abort ? 1 : 3;
        e.ack_err = nack;
        e.len     = QTR * (4 + 4 * (abort ? 9 : 27) + 4);
        return e;
    endfunction

    // Behavioural slave / bus decoder.
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         bitc = 0;
    logic [7:0] sh = 8'd0;
    logic       in_ack = 1'b0;
    logic       byte_done = 1'b0;
    logic       addr_match = 1'b0;
    logic [7:0] cap[$];
    int         n_start = 0;
    int         n_stop = 0;

    always @(negedge clk) begin
        if (scl && scl_p && sda_p && !sda) begin
            n_start++;
            bitc = 0; in_ack = 1'b0; byte_done = 1'b0; slave_drive = 1'b0;
            cap.delete();
        end else if (scl && scl_p && !sda_p && sda) begin
            n_stop++;
        end else if (scl && !scl_p) begin
            if (!in_ack) begin
                sh = {sh[6:0], sda};
                bitc++;
                if (bitc == 8) begin
                    cap.push_back(sh);
                    byte_done = 1'b1;
                    bitc = 0;
                end
            end
        end else if (!scl && scl_p) begin
            if (byte_done) begin
                byte_done = 1'b0;
                in_ack = 1'b1;
                if (cap.size() == 1) addr_match = (sh == 8'h84);
                slave_drive = addr_match;
            end else if (in_ack) begin
                in_ack = 1'b0;
                slave_drive = 1'b0;
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    // Scoreboard monitor: pops on every done pulse.
    logic        busy_p = 1'b0;
    logic        chk_low = 1'b0;
    int          busy_cnt = 0;
    int          start0 = 0;
    int          stop0 = 0;
    exp_t        me;
    logic [23:0] eb;

    always @(negedge clk) begin
        if (chk_low) begin
            check("done_one_cycle", hif.done, 0);
            chk_low = 1'b0;
        end
        if (hif.busy && !busy_p) begin
            busy_cnt = 0;
            start0   = n_start;
            stop0    = n_stop;
        end
        if (hif.busy) busy_cnt++;
        if (hif.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                me = exp_q.pop_front();
                eb = me.bytes;
                check("byte_count", cap.size(), me.nbytes);
                for (int i = 0; i < me.nbytes && i < cap.size(); i++)
                    check($sformatf("byte%0d", i), cap[i], eb[23-8*i -: 8]);
                check("ack_err", hif.ack_err, me.ack_err);
                check("latency", busy_cnt, me.len);
                check("start_cond", n_start - start0, 1);
                check("stop_cond", n_stop - stop0, 1);
                check("busy_low_at_done", hif.busy, 0);
            end
            chk_low = 1'b1;
        end
        busy_p = hif.busy;
    end

    task automatic pulse(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        @(posedge clk); #1;
        hif.start = 1'b1; hif.slv_addr = a; hif.reg_addr = r; hif.wdata = d;
        @(posedge clk); #1;
        hif.start = 1'b0;
    endtask

    task automatic write(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back(model(a, r, d));
        pulse(a, r, d);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            if (hif.done) seen = 1'b1;
            n++;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        reset = 1'b0;
        hif.start = 1'b0; hif.slv_addr = 7'd0; hif.reg_addr = 8'd0; hif.wdata = 8'd0;
        repeat (3) @(posedge clk); #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", hif.busy, 0);
        check("rst_done", hif.done, 0);
        check("rst_ack_err", hif.ack_err, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Basic ACKed write, then a NACKed address.
        write(7'h42, 8'h02, 8'h5A);
        check("busy_after_start", hif.busy, 1);
        wait_done();
        write(7'h10, 8'h33, 8'hC3);
        wait_done();

        // Start while busy must be ignored.
        write(7'h42, 8'h11, 8'h22);
        repeat (200) @(posedge clk);
        pulse(7'h55, 8'hEE, 8'h77);
        wait_done();
        repeat (20) @(posedge clk); #1;
        check("busy_start_ignored", hif.busy, 0);

        // Start in the done cycle must be ignored.
        write(7'h42, 8'h04, 8'hA5);
        repeat (1160) @(posedge clk); #1;
        hif.start = 1'b1; hif.reg_addr = 8'h99;
        @(posedge clk); #1 hif.start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("done_start_ignored", hif.busy, 0);

        // Reset during the REG byte, then a normal write.
        pulse(7'h42, 8'h77, 8'h66);
        repeat (574) @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_busy", hif.busy, 0);
        @(posedge clk); #1;
        check("midrst_scl_clk", scl, 1);
        check("midrst_sda_clk", sda, 1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        write(7'h42, 8'h03, 8'h01);
        wait_done();

        // Back-to-back: NACKed write followed immediately by a good one.
        write(7'h10, 8'h21, 8'h43);
        wait_done();
        write(7'h42, 8'h00, 8'hFF);
        check("b2b_ack_err_cleared", hif.ack_err, 0);
        check("b2b_busy", hif.busy, 1);
        wait_done();

        // Randomized writes.
        for (int k = 0; k < 6; k++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom);
            write(a, 8'($urandom), 8'($urandom));
            wait_done();
        end

        repeat (20) @(posedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
